// File: rtl/wb_dma_copier_pkg.sv
// rtl/wb_dma_copier_pkg.sv - shared register map, bit positions and engine states
package wb_dma_copier_pkg;

    localparam logic [31:0] REG_CONTROL = 32'd0;
    localparam logic [31:0] REG_STATUS  = 32'd1;
    localparam logic [31:0] REG_SRC     = 32'd2;
    localparam logic [31:0] REG_DST     = 32'd3;
    localparam logic [31:0] REG_COUNT   = 32'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_INT_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERROR   = 2;
    localparam int STAT_ABORTED = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_NEXT = 3'd4
    } dma_state_e;

    // Merge a slave write into an existing word honouring byte selects
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - word-copy FSM with address/count counters and ack timeout
module dma_copy_engine import wb_dma_copier_pkg::*; #(
    parameter int TIMEOUT     = 255,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            cfg_src,
    input  logic [31:0]            cfg_dst,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    output logic                   busy,
    output logic                   done_set,
    output logic                   error_set,
    output logic                   aborted_set,
    output logic                   status_clear,
    output logic                   o_mem_we,
    output logic                   o_mem_cyc,
    output logic                   o_mem_stb,
    output logic [3:0]             o_mem_sel,
    output logic [31:0]            o_mem_adr,
    output logic [31:0]            o_mem_dat,
    input  logic [31:0]            i_mem_dat,
    input  logic                   i_mem_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);

    dma_state_e             state_q, state_d;
    logic [31:0]            src_q, src_d, dst_q, dst_d, buf_q, buf_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   phase_timeout;

    // State and working registers; reset drops the bus immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            buf_q        <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign phase_timeout = (timer_q == TW'(TIMEOUT - 1));

    // Next-state logic; an abort is only honoured at a phase boundary
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        abort_pend_d = abort_pend_q | (abort & (state_q != ST_IDLE));
        done_set     = 1'b0;
        error_set    = 1'b0;
        aborted_set  = 1'b0;
        status_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                timer_d      = '0;
                if (start) begin
                    if (cfg_count == '0) begin
                        done_set = 1'b1;
                    end else begin
                        status_clear = 1'b1;
                        src_d        = cfg_src;
                        dst_d        = cfg_dst;
                        cnt_d        = cfg_count;
                        state_d      = ST_RD;
                    end
                end
            end
            ST_RD, ST_WR: begin
                if (i_mem_ack || phase_timeout) begin
                    timer_d = '0;
                    if (i_mem_ack && state_q == ST_RD) buf_d = i_mem_dat;
                    if (!i_mem_ack) error_set = 1'b1;
                    if (abort_pend_q) aborted_set = 1'b1;
                    if (!i_mem_ack || abort_pend_q) state_d = ST_IDLE;
                    else state_d = (state_q == ST_RD) ? ST_GAP : ST_NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (abort_pend_q) begin
                    aborted_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_NEXT: begin
                src_d = src_q + 32'd1;
                dst_d = dst_q + 32'd1;
                cnt_d = cnt_q - 1'b1;
                if (abort_pend_q) begin
                    aborted_set = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q == COUNT_WIDTH'(1)) begin
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the registered state
    always_comb begin
        busy      = (state_q != ST_IDLE);
        o_mem_cyc = (state_q == ST_RD) || (state_q == ST_WR);
        o_mem_stb = o_mem_cyc;
        o_mem_we  = (state_q == ST_WR);
        o_mem_sel = o_mem_cyc ? 4'hF : 4'h0;
        o_mem_adr = (state_q == ST_RD) ? src_q : ((state_q == ST_WR) ? dst_q : 32'd0);
        o_mem_dat = buf_q;
    end

endmodule

// File: rtl/wb_dma_copier.sv
// rtl/wb_dma_copier.sv - slave register file and handshake around the copy engine
module wb_dma_copier import wb_dma_copier_pkg::*; #(
    parameter int TIMEOUT     = 255,
    parameter int COUNT_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wbs_we,
    input  logic        i_wbs_cyc,
    input  logic        i_wbs_stb,
    input  logic [3:0]  i_wbs_sel,
    input  logic [31:0] i_wbs_adr,
    input  logic [31:0] i_wbs_dat,
    output logic        o_wbs_ack,
    output logic [31:0] o_wbs_dat,
    output logic        o_wbs_int,
    output logic        o_mem_we,
    output logic        o_mem_cyc,
    output logic        o_mem_stb,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_mem_int
);

    logic                   ack_q, ack_d, int_q, int_d;
    logic [31:0]            rdata_q, rdata_d, src_q, src_d, dst_q, dst_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   int_en_q, int_en_d;
    logic                   done_q, done_d, error_q, error_d, aborted_q, aborted_d;
    logic                   req, wr_req, rd_req, start_pulse, abort_pulse;
    logic [3:0]             w1c_mask;
    logic                   busy, eng_done, eng_error, eng_aborted, eng_clear;
    logic                   unused_mem_int;

    assign unused_mem_int = i_mem_int;
    assign req    = i_wbs_cyc & i_wbs_stb & ~ack_q;
    assign wr_req = req & i_wbs_we;
    assign rd_req = req & ~i_wbs_we;

    // Register state, ack, read data and interrupt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q     <= 1'b0;
            int_q     <= 1'b0;
            rdata_q   <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            int_en_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            int_q     <= int_d;
            rdata_q   <= rdata_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            count_q   <= count_d;
            int_en_q  <= int_en_d;
            done_q    <= done_d;
            error_q   <= error_d;
            aborted_q <= aborted_d;
        end
    end

    // Slave decode: register writes, command pulses and read mux
    always_comb begin
        ack_d       = req;
        rdata_d     = '0;
        src_d       = src_q;
        dst_d       = dst_q;
        count_d     = count_q;
        int_en_d    = int_en_q;
        start_pulse = 1'b0;
        abort_pulse = 1'b0;
        w1c_mask    = 4'h0;
        if (wr_req) begin
            case (i_wbs_adr)
                REG_CONTROL: if (i_wbs_sel[0]) begin
                    int_en_d    = i_wbs_dat[CTRL_INT_EN];
                    start_pulse = i_wbs_dat[CTRL_START] & ~busy;
                    abort_pulse = i_wbs_dat[CTRL_ABORT] & busy;
                end
                REG_STATUS:  if (i_wbs_sel[0]) w1c_mask = i_wbs_dat[3:0];
                REG_SRC:     if (!busy) src_d = apply_sel(src_q, i_wbs_dat, i_wbs_sel);
                REG_DST:     if (!busy) dst_d = apply_sel(dst_q, i_wbs_dat, i_wbs_sel);
                REG_COUNT:   if (!busy) count_d = COUNT_WIDTH'(apply_sel(32'(count_q), i_wbs_dat, i_wbs_sel));
                default: ;
            endcase
        end
        if (rd_req) begin
            case (i_wbs_adr)
                REG_CONTROL: rdata_d = {29'd0, 1'b0, int_en_q, 1'b0};
                REG_STATUS:  rdata_d = {28'd0, aborted_q, error_q, done_q, busy};
                REG_SRC:     rdata_d = src_q;
                REG_DST:     rdata_d = dst_q;
                REG_COUNT:   rdata_d = 32'(count_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // Sticky status: software clear first, then engine clear/set from the same cycle
    always_comb begin
        done_d    = done_q    & ~w1c_mask[STAT_DONE];
        error_d   = error_q   & ~w1c_mask[STAT_ERROR];
        aborted_d = aborted_q & ~w1c_mask[STAT_ABORTED];
        if (eng_clear) begin
            done_d    = 1'b0;
            error_d   = 1'b0;
            aborted_d = 1'b0;
        end
        if (eng_done)    done_d    = 1'b1;
        if (eng_error)   error_d   = 1'b1;
        if (eng_aborted) aborted_d = 1'b1;
        int_d = int_en_q & (done_q | error_q | aborted_q);
    end

    assign o_wbs_ack = ack_q;
    assign o_wbs_dat = rdata_q;
    assign o_wbs_int = int_q;

    dma_copy_engine #(
        .TIMEOUT     (TIMEOUT),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_engine (
        .clk          (clk),
        .rst          (rst),
        .start        (start_pulse),
        .abort        (abort_pulse),
        .cfg_src      (src_q),
        .cfg_dst      (dst_q),
        .cfg_count    (count_q),
        .busy         (busy),
        .done_set     (eng_done),
        .error_set    (eng_error),
        .aborted_set  (eng_aborted),
        .status_clear (eng_clear),
        .o_mem_we     (o_mem_we),
        .o_mem_cyc    (o_mem_cyc),
        .o_mem_stb    (o_mem_stb),
        .o_mem_sel    (o_mem_sel),
        .o_mem_adr    (o_mem_adr),
        .o_mem_dat    (o_mem_dat),
        .i_mem_dat    (i_mem_dat),
        .i_mem_ack    (i_mem_ack)
    );

endmodule

// File: tb/tb_wb_dma_copier.sv
// tb/tb_wb_dma_copier.sv - directed self-checking bench for wb_dma_copier
module tb_wb_dma_copier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_wbs_we = 1'b0, i_wbs_cyc = 1'b0, i_wbs_stb = 1'b0;
    logic [3:0]  i_wbs_sel = 4'h0;
    logic [31:0] i_wbs_adr = '0, i_wbs_dat = '0;
    logic        o_wbs_ack, o_wbs_int;
    logic [31:0] o_wbs_dat;
    logic        o_mem_we, o_mem_cyc, o_mem_stb;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_adr, o_mem_dat;
    logic [31:0] i_mem_dat;
    logic        i_mem_ack;
    logic        i_mem_int = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rom [0:255];
    logic [31:0] ram [0:255];
    logic        ack_en = 1'b1;
    int          rd_cnt = 0, wr_cnt = 0, cyc_cnt = 0, stb_cnt = 0;

    always #5 clk = ~clk;

    wb_dma_copier #(.TIMEOUT(8), .COUNT_WIDTH(24)) dut (
        .clk(clk), .rst(rst),
        .i_wbs_we(i_wbs_we), .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb),
        .i_wbs_sel(i_wbs_sel), .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat),
        .o_wbs_ack(o_wbs_ack), .o_wbs_dat(o_wbs_dat), .o_wbs_int(o_wbs_int),
        .o_mem_we(o_mem_we), .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb),
        .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
        .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int)
    );

    // Memory slave: one-wait-state ack, reads from rom, writes into ram
    assign i_mem_dat = rom[o_mem_adr[7:0]];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_mem_ack <= 1'b0;
        end else begin
            i_mem_ack <= ack_en & o_mem_cyc & o_mem_stb & ~i_mem_ack;
            if (i_mem_ack && o_mem_we) begin
                ram[o_mem_adr[7:0]] <= o_mem_dat;
                wr_cnt <= wr_cnt + 1;
            end
            if (i_mem_ack && !o_mem_we) rd_cnt <= rd_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (o_mem_cyc) cyc_cnt <= cyc_cnt + 1;
        if (o_mem_stb) stb_cnt <= stb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output logic [31:0] rdat);
        logic got = 1'b0;
        @(negedge clk);
        i_wbs_we = we; i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1;
        i_wbs_sel = 4'hF; i_wbs_adr = adr; i_wbs_dat = dat;
        rdat = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (o_wbs_ack) begin got = 1'b1; rdat = o_wbs_dat; break; end
        end
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; i_wbs_we = 1'b0;
        if (!got) check("wbs_ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_cycle(1'b1, adr, dat, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        wb_cycle(1'b0, adr, 32'd0, dat);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st = 32'h1;
        for (int i = 0; i < 300 && st[0]; i++) wb_read(32'd1, st);
        check(tag, {31'd0, st[0]}, 32'd0);
    endtask

    logic [31:0] rd;
    int base_rd, base_wr, base_cyc, base_stb, n;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hDEAD_0000 + i;
        for (int i = 0; i < 4; i++)  rom[8'h10 + i] = 32'hA0 + i;

        // Reset state
        #3;
        check("rst_mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
        check("rst_wbs_ack", {31'd0, o_wbs_ack}, 32'd0);
        check("rst_wbs_int", {31'd0, o_wbs_int}, 32'd0);
        check("rst_wbs_dat", o_wbs_dat, 32'd0);
        @(negedge clk); rst = 1'b1;
        wb_read(32'd1, rd); check("rst_status", rd, 32'd0);
        wb_read(32'd4, rd); check("rst_count", rd, 32'd0);

        // Four-word copy 0x10 -> 0x80
        base_rd = rd_cnt; base_wr = wr_cnt;
        wb_write(32'd2, 32'h10);
        wb_write(32'd3, 32'h80);
        wb_write(32'd4, 32'd4);
        wb_write(32'd0, 32'h1);
        wait_idle("copy4_idle");
        wb_read(32'd1, rd); check("copy4_status", rd, 32'h2);
        for (int i = 0; i < 4; i++) check($sformatf("copy4_ram%0d", i), ram[8'h80 + i], 32'hA0 + i);
        check("copy4_reads", rd_cnt - base_rd, 32'd4);
        check("copy4_writes", wr_cnt - base_wr, 32'd4);
        wb_read(32'd0, rd); check("ctrl_start_reads0", rd, 32'd0);
        check("copy4_int_off", {31'd0, o_wbs_int}, 32'd0);
        wb_read(32'd7, rd); check("unmapped_read", rd, 32'd0);

        // Zero-count start: DONE with no bus activity
        base_cyc = cyc_cnt;
        wb_write(32'd1, 32'hE);
        wb_read(32'd1, rd); check("w1c_all", rd, 32'd0);
        wb_write(32'd4, 32'd0);
        wb_write(32'd0, 32'h1);
        repeat (2) @(posedge clk);
        wb_read(32'd1, rd); check("zero_done", rd, 32'h2);
        check("zero_no_cyc", cyc_cnt - base_cyc, 32'd0);

        // Timeout: no ack, 8 cycles of stb then ERROR and interrupt
        ack_en = 1'b0;
        wb_write(32'd2, 32'h20);
        wb_write(32'd4, 32'd1);
        base_stb = stb_cnt;
        wb_write(32'd0, 32'h3);
        wait_idle("tmo_idle");
        check("tmo_stb_cycles", stb_cnt - base_stb, 32'd8);
        wb_read(32'd1, rd); check("tmo_status", rd, 32'h4);
        check("tmo_int", {31'd0, o_wbs_int}, 32'd1);
        wb_write(32'd1, 32'h6);
        wb_read(32'd1, rd); check("tmo_w1c", rd, 32'd0);
        check("tmo_int_clr", {31'd0, o_wbs_int}, 32'd0);
        ack_en = 1'b1;

        // Abort during a 16-word copy, plus writes ignored while busy
        for (int i = 0; i < 16; i++) rom[8'h30 + i] = 32'hB000 + i;
        wb_write(32'd2, 32'h30);
        wb_write(32'd3, 32'h90);
        wb_write(32'd4, 32'd16);
        base_wr = wr_cnt;
        wb_write(32'd0, 32'h3);
        wb_write(32'd2, 32'h55);
        wb_read(32'd2, rd); check("busy_src_kept", rd, 32'h30);
        n = 0;
        while (wr_cnt - base_wr < 2 && n < 500) begin @(negedge clk); n++; end
        check("abort_two_writes", {31'd0, (wr_cnt - base_wr >= 2)}, 32'd1);
        wb_write(32'd0, 32'h6);
        wait_idle("abort_idle");
        wb_read(32'd1, rd); check("abort_status", rd, 32'h8);
        check("abort_max3", {31'd0, (wr_cnt - base_wr <= 3)}, 32'd1);
        check("abort_ram0", ram[8'h90], 32'hB000);
        check("abort_ram1", ram[8'h91], 32'hB001);
        check("abort_int", {31'd0, o_wbs_int}, 32'd1);

        // Reset in the middle of a write phase
        wb_write(32'd1, 32'hE);
        wb_write(32'd0, 32'h1);
        n = 0;
        while (!o_mem_we && n < 200) begin @(negedge clk); n++; end
        check("rst_we_seen", {31'd0, o_mem_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("midrst_cyc", {31'd0, o_mem_cyc}, 32'd0);
        check("midrst_stb", {31'd0, o_mem_stb}, 32'd0);
        check("midrst_int", {31'd0, o_wbs_int}, 32'd0);
        @(negedge clk); rst = 1'b1;
        base_cyc = cyc_cnt;
        wb_read(32'd1, rd); check("midrst_status", rd, 32'd0);
        wb_read(32'd2, rd); check("midrst_src", rd, 32'd0);
        repeat (20) @(posedge clk);
        check("midrst_no_resume", cyc_cnt - base_cyc, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
